// File: rtl/oric_tap_pkg.sv
// oric_tap_pkg: shared constants and state encoding for the Oric TAP loader
package oric_tap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_MARK,
        ST_HDR,
        ST_NAME,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } tap_state_t;

    localparam logic [7:0] TAP_SYNC       = 8'h16;
    localparam logic [7:0] TAP_MARK       = 8'h24;
    localparam int         TAP_HDR_LEN    = 9;
    localparam logic [7:0] TAP_TYPE_BASIC = 8'h00;
    localparam logic [7:0] TAP_TYPE_MC    = 8'h80;

endpackage

// File: rtl/tap_loader.sv
// tap_loader: parse the first file of an Oric .TAP download into direct RAM writes
module tap_loader
    import oric_tap_pkg::*;
#(
    parameter int MIN_SYNC = 3,
    parameter int NAME_MAX = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] tape_addr,
    output logic [7:0]  tape_dout,
    output logic        tape_wr,
    output logic [15:0] loadpoint,
    output logic [7:0]  file_type,
    output logic        tape_autorun,
    output logic        tape_complete,
    output logic        busy,
    output logic        error
);

    tap_state_t  state, cur;
    logic        dl_prev, dl_rise, dl_fall, auto_flag;
    logic [7:0]  sync_cnt, cnt, name_cnt;
    logic [3:0]  hdr_idx;
    logic [15:0] end_addr, start_addr, addr;
    logic [16:0] remaining;

    // A new download restarts parsing in the same cycle, so a byte arriving with the edge is parsed as a sync byte
    always_comb begin
        dl_rise = ioctl_download & ~dl_prev;
        dl_fall = ~ioctl_download & dl_prev;
        cur     = dl_rise ? ST_SYNC : state;
        cnt     = dl_rise ? 8'd0 : sync_cnt;
    end

    assign busy  = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign error = state == ST_ERR;

    // Parser state machine and RAM write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            dl_prev       <= 1'b0;
            sync_cnt      <= '0;
            name_cnt      <= '0;
            hdr_idx       <= '0;
            end_addr      <= '0;
            start_addr    <= '0;
            addr          <= '0;
            remaining     <= '0;
            auto_flag     <= 1'b0;
            tape_addr     <= '0;
            tape_dout     <= '0;
            tape_wr       <= 1'b0;
            loadpoint     <= '0;
            file_type     <= '0;
            tape_autorun  <= 1'b0;
            tape_complete <= 1'b0;
        end else begin
            dl_prev       <= ioctl_download;
            tape_wr       <= 1'b0;
            tape_complete <= 1'b0;
            if (dl_rise) begin
                state        <= ST_SYNC;
                sync_cnt     <= '0;
                name_cnt     <= '0;
                hdr_idx      <= '0;
                tape_autorun <= 1'b0;
            end
            if (dl_fall && busy) begin
                state <= ST_ERR;
            end else if (ioctl_wr) begin
                case (cur)
                    ST_SYNC: begin
                        if (ioctl_dout == TAP_SYNC)
                            sync_cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                        else if (ioctl_dout == TAP_MARK && cnt >= 8'(MIN_SYNC)) begin
                            state   <= ST_HDR;
                            hdr_idx <= '0;
                        end else
                            state <= ST_ERR;
                    end
                    ST_HDR: begin
                        hdr_idx <= hdr_idx + 4'd1;
                        case (hdr_idx)
                            4'd2: file_type <= ioctl_dout;
                            4'd3: auto_flag <= |ioctl_dout;
                            4'd4: end_addr[15:8] <= ioctl_dout;
                            4'd5: end_addr[7:0] <= ioctl_dout;
                            4'd6: start_addr[15:8] <= ioctl_dout;
                            4'd7: start_addr[7:0] <= ioctl_dout;
                            default: ;
                        endcase
                        if (hdr_idx == 4'(TAP_HDR_LEN - 1)) begin
                            if (end_addr < start_addr)
                                state <= ST_ERR;
                            else begin
                                loadpoint <= start_addr;
                                addr      <= start_addr;
                                remaining <= {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
                                state     <= ST_NAME;
                            end
                        end
                    end
                    ST_NAME: begin
                        if (ioctl_dout == 8'h00)
                            state <= ST_DATA;
                        else if (name_cnt == 8'(NAME_MAX))
                            state <= ST_ERR;
                        else
                            name_cnt <= name_cnt + 8'd1;
                    end
                    ST_DATA: begin
                        tape_wr   <= 1'b1;
                        tape_addr <= addr;
                        tape_dout <= ioctl_dout;
                        addr      <= addr + 16'd1;
                        remaining <= remaining - 17'd1;
                        if (remaining == 17'd1) begin
                            tape_complete <= 1'b1;
                            tape_autorun  <= auto_flag;
                            state         <= ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tap_loader.sv
// tb_tap_loader: table-driven checks of the TAP loader plus restart and reset corner cases
module tb_tap_loader;
    import oric_tap_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        string       nm;
        int          off;
        int          n;
        int          drop;
        int          nwr;
        int          doff;
        logic [15:0] start;
        logic [7:0]  ft;
        logic        au;
        logic        er;
    } vec_t;

    logic        clk = 0, reset_n = 0, ioctl_download = 0, ioctl_wr = 0;
    logic [7:0]  ioctl_dout = 0;
    logic [15:0] tape_addr, loadpoint;
    logic [7:0]  tape_dout, file_type;
    logic        tape_wr, tape_autorun, tape_complete, busy, error;

    int checks = 0, errors = 0;
    int wr_total = 0, cmp_total = 0, cmp_at = 0;
    logic cmp_wr = 0, cmp_auto = 0;
    logic [15:0] wa[256];
    logic [7:0]  wd[256];
    logic [7:0]  pool[$];
    vec_t        vecs[$];

    tap_loader #(.MIN_SYNC(3), .NAME_MAX(16)) dut (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout), .tape_addr(tape_addr), .tape_dout(tape_dout), .tape_wr(tape_wr),
        .loadpoint(loadpoint), .file_type(file_type), .tape_autorun(tape_autorun),
        .tape_complete(tape_complete), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tape_wr) begin
            wa[wr_total & 255] = tape_addr;
            wd[wr_total & 255] = tape_dout;
            wr_total++;
        end
        if (tape_complete) begin
            cmp_total++;
            cmp_at   = wr_total;
            cmp_wr   = tape_wr;
            cmp_auto = tape_autorun;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input byte_q_t q, input int drop, input int nwr, input int doff,
                           input logic [15:0] start, input logic [7:0] ft, input logic au, input logic er);
        vec_t v;
        v.nm = nm; v.off = pool.size(); v.n = q.size(); v.drop = drop; v.nwr = nwr; v.doff = doff;
        v.start = start; v.ft = ft; v.au = au; v.er = er;
        foreach (q[i]) pool.push_back(q[i]);
        vecs.push_back(v);
    endtask

    task automatic run(input vec_t v);
        int wb, cb;
        wb = wr_total;
        cb = cmp_total;
        @(posedge clk); #1;
        ioctl_download = 1;
        for (int i = 0; i < v.n && i != v.drop; i++) begin
            ioctl_wr   = 1;
            ioctl_dout = pool[v.off + i];
            @(posedge clk); #1;
        end
        ioctl_wr = 0;
        if (v.drop < 0) begin
            repeat (3) @(posedge clk);
            #1;
        end
        ioctl_download = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({v.nm, ".writes"}, wr_total - wb, v.nwr);
        chk({v.nm, ".error"}, error, v.er);
        chk({v.nm, ".busy"}, busy, 0);
        chk({v.nm, ".complete"}, cmp_total - cb, !v.er);
        if (!v.er) begin
            chk({v.nm, ".cmp_with_last"}, cmp_at - wb, v.nwr);
            chk({v.nm, ".cmp_wr"}, cmp_wr, 1);
            chk({v.nm, ".loadpoint"}, loadpoint, v.start);
            chk({v.nm, ".file_type"}, file_type, v.ft);
            chk({v.nm, ".autorun_at_cmp"}, cmp_auto, v.au);
        end
        chk({v.nm, ".autorun"}, tape_autorun, v.er ? 1'b0 : v.au);
        for (int k = 0; k < v.nwr && k < wr_total - wb; k++) begin
            chk({v.nm, ".addr"}, wa[(wb + k) & 255], 16'(v.start + 16'(k)));
            chk({v.nm, ".data"}, wd[(wb + k) & 255], pool[v.off + v.doff + k]);
        end
    endtask

    initial begin
        byte_q_t q;
        int wb, cb;
        q = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'h01, 8'h05, 8'h05, 8'h05, 8'h00, 8'h00,
              8'h41, 8'h42, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h01, 8'h55, 8'h66};
        add_vec("valid", q, -1, 6, 16, 16'h0500, TAP_TYPE_MC, 1, 0);
        q = '{8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'h01};
        add_vec("bad_sync", q, -1, 0, 0, 16'h0000, 8'h00, 0, 1);
        q = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'hFF, 8'h05, 8'h00, 8'h00,
              8'h41, 8'h00, 8'hAA, 8'hBB};
        add_vec("end_lt_start", q, -1, 0, 0, 16'h0000, 8'h00, 0, 1);
        q = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'h01, 8'h05, 8'h05, 8'h05, 8'h00, 8'h00,
              8'h41, 8'h42, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h01};
        add_vec("truncated", q, 19, 3, 16, 16'h0500, 8'h00, 0, 1);
        q = '{8'h16, 8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h00, 8'h5A, 8'h77};
        add_vec("wrap_ffff", q, -1, 1, 15, 16'hFFFF, TAP_TYPE_BASIC, 0, 0);
        q = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00};
        for (int i = 0; i < 17; i++) q.push_back(8'h41);
        q.push_back(8'h00);
        q.push_back(8'h77);
        add_vec("name_17", q, -1, 0, 0, 16'h0000, 8'h00, 0, 1);
        q = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) q.push_back(8'h41);
        q.push_back(8'h00);
        q.push_back(8'h77);
        add_vec("name_16", q, -1, 1, 30, 16'h1000, TAP_TYPE_BASIC, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.wr", tape_wr, 0);
        chk("reset.addr", tape_addr, 0);
        chk("reset.dout", tape_dout, 0);
        chk("reset.loadpoint", loadpoint, 0);
        chk("reset.file_type", file_type, 0);
        chk("reset.flags", {tape_autorun, tape_complete, busy, error}, 4'b0000);
        @(posedge clk); #1;
        reset_n = 1;

        foreach (vecs[i]) run(vecs[i]);

        @(posedge clk); #1;
        ioctl_download = 1;
        for (int i = 0; i < 14; i++) begin
            ioctl_wr   = 1;
            ioctl_dout = pool[vecs[0].off + i];
            @(posedge clk); #1;
        end
        ioctl_wr = 0;
        @(negedge clk);
        chk("restart.busy_in_name", busy, 1);
        #1 ioctl_download = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("restart.error", error, 1);
        run(vecs[0]);

        wb = wr_total;
        cb = cmp_total;
        @(posedge clk); #1;
        ioctl_download = 1;
        for (int i = 0; i < 18; i++) begin
            ioctl_wr   = 1;
            ioctl_dout = pool[vecs[0].off + i];
            @(posedge clk); #1;
        end
        ioctl_wr = 0;
        @(negedge clk); #1;
        reset_n = 0;
        ioctl_download = 0;
        #1;
        chk("areset.wr_now", tape_wr, 0);
        chk("areset.busy_now", busy, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("areset.writes", wr_total - wb, 2);
        chk("areset.complete", cmp_total - cb, 0);
        chk("areset.loadpoint", loadpoint, 0);
        chk("areset.error", error, 0);

        run(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
